ama_add_arbiter: RTL and testbench



---
 rtl/ama_pkg.sv | 50 +++++
 rtl/ama_add_arbiter_rr_arbiter.sv | 52 +++++
 rtl/ama_add_arbiter.sv | 133 +++++++++++++
 tb/tb_ama_add_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_pkg.sv
// Shared types, default sizes and the approximate/exact add rule.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// ama_appr_add() works on 64-bit containers.
// Callers zero-extend operands of any WIDTH up to 63 bits.
// The result {cout, sum} is returned in the low width+1 bits.
package ama_pkg;

  localparam int AMA_WIDTH     = 32;
  localparam int AMA_APPR_BITS = 8;
  localparam int AMA_NREQ      = 4;
  localparam int AMA_IDW       = $clog2(AMA_NREQ);
  localparam int AMA_MAXW      = 64;

  typedef struct packed {
    logic [AMA_WIDTH-1:0] sum;
    logic                 cout;
    logic [AMA_IDW-1:0]   id;
    logic                 appr;
  } ama_rsp_t;

  // Exact:  {cout,sum} = a + b + cin.
  // Approx: low appr_bits are a|b.
  //         The carry into the upper part is the AND of the top low-part bits.
  //         cin is ignored in this mode.
  function automatic logic [AMA_MAXW:0] ama_appr_add(
    input logic [AMA_MAXW-1:0] a,
    input logic [AMA_MAXW-1:0] b,
    input logic                cin,
    input logic                appr,
    input int unsigned         width     = AMA_WIDTH,
    input int unsigned         appr_bits = AMA_APPR_BITS
  );
    logic [AMA_MAXW:0] wmask, lmask, a_m, b_m, low, hi, cbit;
    wmask = ({{AMA_MAXW{1'b0}}, 1'b1} << width) - 1'b1;
    a_m   = {1'b0, a} & wmask;
    b_m   = {1'b0, b} & wmask;
    if (!appr) begin
      ama_appr_add = a_m + b_m + {{AMA_MAXW{1'b0}}, cin};
    end else begin
      lmask = ({{AMA_MAXW{1'b0}}, 1'b1} << appr_bits) - 1'b1;
      low   = (a_m | b_m) & lmask;
      cbit  = ((a_m & b_m) >> (appr_bits - 1)) & {{AMA_MAXW{1'b0}}, 1'b1};
      hi    = (a_m >> appr_bits) + (b_m >> appr_bits) + cbit;
      ama_appr_add = (hi << appr_bits) | low;
    end
  endfunction

endpackage

// File: rtl/ama_add_arbiter_rr_arbiter.sv
// Round-robin grant: search from rr_ptr upward with wrap, one-hot grant.
// Latency: grant is combinational; the pointer moves on the clock after a grant.
// Backpressure: en=0 suppresses every grant and freezes the pointer.
//
// Ports:
//   clk, rst_n - clock and async active-low reset
//   en         - slot available this cycle
//   req        - request vector
//   gnt        - one-hot grant (zero when nothing is granted)
//   gnt_id     - index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] rr_ptr;
  logic           found;
  int             idx;

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          found  = 1'b1;
          gnt_id = IDW'(idx);
        end
      end
    end
    gnt = found ? (NREQ'(1) << gnt_id) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/ama_add_arbiter.sv
// Shares one approximate/exact adder between NREQ requesters.
// Requesters are served round-robin.
// Latency: 1 cycle from accept to registered response.
// Backpressure: rsp_valid & !rsp_ready holds the response and drops every req_ready.
//   Drain and accept may happen in the same cycle.
//
// Ports:
//   req_valid/req_ready        - per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b                - operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin/req_appr           - carry-in and mode (1 = approximate low APPR_BITS)
//   rsp_valid/rsp_ready        - single response handshake
//   rsp_sum/rsp_cout/rsp_id/rsp_appr - registered result
//
// Optional macro AMA_ERRSTAT_EN adds three ports:
//   stat_clr - input, clears both statistics
//   appr_cnt - saturating count of approximate operations
//   err_max  - worst |exact - approx| seen
//
// WIDTH may be at most 63.
module ama_add_arbiter
  import ama_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = AMA_WIDTH,
  parameter int APPR_BITS = AMA_APPR_BITS,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_appr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_appr
`ifdef AMA_ERRSTAT_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           appr_cnt,
  output logic [WIDTH:0]        err_max
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [IDW-1:0]   id;
    logic             appr;
  } rsp_t;

  logic            slot_free;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic            cin_sel, appr_sel;
  logic [WIDTH:0]  res;
  rsp_t            rsp_d, rsp_q;

  assign slot_free = !rsp_valid || rsp_ready;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (slot_free),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // The grant only goes to a valid requester, so any grant is a transfer.
  assign req_ready = rst_n ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    a_sel    = req_a[gnt_id*WIDTH +: WIDTH];
    b_sel    = req_b[gnt_id*WIDTH +: WIDTH];
    cin_sel  = req_cin[gnt_id];
    appr_sel = req_appr[gnt_id];
    res = (WIDTH+1)'(ama_appr_add(AMA_MAXW'(a_sel), AMA_MAXW'(b_sel), cin_sel,
                                  appr_sel, WIDTH, APPR_BITS));
    rsp_d.sum  = res[WIDTH-1:0];
    rsp_d.cout = res[WIDTH];
    rsp_d.id   = gnt_id;
    rsp_d.appr = appr_sel;
  end

  // The old result leaves and the new one lands on the same edge, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (slot_free) begin
      rsp_valid <= xfer;
      if (xfer) rsp_q <= rsp_d;
    end
  end

  assign rsp_sum  = rsp_q.sum;
  assign rsp_cout = rsp_q.cout;
  assign rsp_id   = rsp_q.id;
  assign rsp_appr = rsp_q.appr;

`ifdef AMA_ERRSTAT_EN
  logic [WIDTH:0] exact_res, err_abs;

  always_comb begin
    exact_res = (WIDTH+1)'(ama_appr_add(AMA_MAXW'(a_sel), AMA_MAXW'(b_sel), cin_sel,
                                        1'b0, WIDTH, APPR_BITS));
    err_abs   = (exact_res > res) ? exact_res - res : res - exact_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      appr_cnt <= '0;
      err_max  <= '0;
    end else if (stat_clr) begin
      appr_cnt <= '0;
      err_max  <= '0;
    end else if (xfer && appr_sel) begin
      if (appr_cnt != '1) appr_cnt <= appr_cnt + 32'd1;
      if (err_abs > err_max) err_max <= err_abs;
    end
  end
`endif

endmodule

// File: tb/tb_ama_add_arbiter.sv
// Bench for ama_add_arbiter.
// A driver issues requests, a reference model queues the expected responses,
// and a monitor compares and pops them.
module tb_ama_add_arbiter;
  import ama_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AB = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready, req_cin = '0, req_appr = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic           rsp_valid, rsp_ready = 1'b1, rsp_cout, rsp_appr;
  logic [W-1:0]   rsp_sum;
  logic [1:0]     rsp_id;

  always #5 clk = ~clk;

  ama_add_arbiter #(.NREQ(N), .WIDTH(W), .APPR_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_appr  (req_appr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .rsp_appr  (rsp_appr)
  );

  int         total = 0;
  int         bad = 0;
  ama_rsp_t   sbq[$];
  logic [W:0] exp_res [N];
  int         mptr = 0;
  bit         logging = 1'b0;
  int         id_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference add, straight from the arithmetic rules.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic appr);
    logic [W:0] lowmask, low, hi, c;
    if (!appr) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    lowmask = (33'd1 << AB) - 33'd1;
    low     = {1'b0, a | b} & lowmask;
    c       = {{W{1'b0}}, a[AB-1] & b[AB-1]};
    hi      = ({1'b0, a} >> AB) + ({1'b0, b} >> AB) + c;
    return (hi << AB) | low;
  endfunction

  // Round-robin choice: the first valid requester at or after the pointer, with wrap.
  function automatic int predict();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
    end
    return -1;
  endfunction

  // Reference model: on each accepting edge, queue the expected response.
  always @(posedge clk) begin : model
    int g;
    ama_rsp_t e;
    if (!rst_n) begin
      mptr = 0;
      sbq.delete();
    end else if (sbq.size() == 0 || rsp_ready) begin
      g = predict();
      if (g >= 0) begin
        e.sum  = exp_res[g][W-1:0];
        e.cout = exp_res[g][W];
        e.id   = 2'(g);
        e.appr = req_appr[g];
        sbq.push_back(e);
        mptr = (g + 1) % N;
      end
    end
  end

  // Monitor: checks the grant and the response, and pops consumed entries.
  always @(negedge clk) begin : monitor
    int g;
    logic [N-1:0] er;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end else begin
      er = '0;
      if (sbq.size() == 0 || rsp_ready) begin
        g = predict();
        if (g >= 0) er[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("rsp_valid", 64'(rsp_valid), 64'(sbq.size() > 0));
      if (rsp_valid && sbq.size() > 0) begin
        chk("rsp_sum",  64'(rsp_sum),  64'(sbq[0].sum));
        chk("rsp_cout", 64'(rsp_cout), 64'(sbq[0].cout));
        chk("rsp_id",   64'(rsp_id),   64'(sbq[0].id));
        chk("rsp_appr", 64'(rsp_appr), 64'(sbq[0].appr));
        if (rsp_ready) begin
          if (logging) id_log.push_back(int'(sbq[0].id));
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic appr, input logic [W:0] e);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
    req_appr[i]     = appr;
    exp_res[i]      = e;
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] a, b;
    logic cin, appr;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(0, 4))
      0: a = 32'hFFFF_FFFF;
      1: begin a = 32'hFFFF_FFFF; b = 32'h1; end
      2: b = {a[31:8], 8'h80};
      default: ;
    endcase
    cin  = 1'($urandom_range(0, 1));
    appr = 1'($urandom_range(0, 1));
    set_op(i, a, b, cin, appr, ref_add(a, b, cin, appr));
  endtask

  // Presents one request alone and waits (bounded) for its acceptance.
  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic appr,
                       input logic [W-1:0] esum, input logic ecout);
    bit ok;
    ok = 1'b0;
    set_op(i, a, b, cin, appr, {ecout, esum});
    req_valid    = '0;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("issue_accept", 64'(ok), 64'd1);
    step();
    req_valid = '0;
  endtask

  initial begin : driver
    int want[12];
    logic [N-1:0] acc;
    want = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

    // Reset with every requester valid.
    for (int i = 0; i < N; i++) rand_op(i);
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_sum",  64'(rsp_sum),  64'd0);
    chk("rst_cout", 64'(rsp_cout), 64'd0);
    chk("rst_id",   64'(rsp_id),   64'd0);
    chk("rst_appr", 64'(rsp_appr), 64'd0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    logging = 1'b1;

    // Fairness: everyone valid, then requester 1 drops out.
    repeat (8) step();
    req_valid[1] = 1'b0;
    repeat (4) step();
    req_valid = '0;
    repeat (2) step();
    logging = 1'b0;
    chk("seq_len", 64'(id_log.size()), 64'd12);
    for (int k = 0; k < 12; k++) begin
      if (k < id_log.size()) chk("seq_id", 64'(id_log[k]), 64'(want[k]));
    end

    // Directed arithmetic cases.
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
    issue(2, 32'h0000_0080, 32'h0000_0080, 1'b0, 1'b1, 32'h0000_0180, 1'b0);
    issue(2, 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_00FF, 1'b0);
    issue(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    issue(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step();

    // Backpressure: the held result stays put, then drains while the next one is granted.
    rsp_ready = 1'b0;
    issue(1, 32'h5, 32'h6, 1'b1, 1'b0, 32'hC, 1'b0);
    set_op(3, 32'h10, 32'h20, 1'b0, 1'b0, 33'h30);
    req_valid[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_sum_held",  64'(rsp_sum),   64'hC);
    end
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_same_cycle_grant", 64'(req_ready), 64'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_sum", 64'(rsp_sum), 64'h30);
    chk("bp_next_id",  64'(rsp_id),  64'd3);
    step();

    // Random traffic, with one reset in the middle.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #2;
      if (c == 250) rst_n = 1'b0;
      if (c == 253) rst_n = 1'b1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc[i]) begin
          // hold stable until accepted
        end else if ($urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          rand_op(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
